// File: rtl/spi_transaction_controller.sv
// SPI transaction sequencer: sits between the SPI byte engine and the
// subperipheral selector. The first byte of each chip-select window is taken
// as the subperipheral address. Later bytes are forwarded as write-data
// strobes, up to a payload limit. A single-entry buffer holds the selected
// subperipheral's response byte for the next shift-out.
module spi_transaction_controller #(
  parameter logic [7:0]  ADDRESS_MIN = 8'hDB,
  parameter logic [7:0]  ADDRESS_MAX = 8'hDC,
  parameter int unsigned MAX_PAYLOAD = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       spi_select_in,
  input  logic [7:0] rx_byte_in,
  input  logic       rx_byte_valid_in,
  output logic [7:0] address_out,
  output logic       address_valid_out,
  output logic [7:0] payload_out,
  output logic       payload_valid_out,
  output logic [7:0] byte_count_out,
  input  logic [7:0] sub_data_in,
  input  logic       sub_data_valid_in,
  output logic [7:0] tx_byte_out,
  output logic       tx_byte_valid_out,
  input  logic       tx_request_in,
  output logic       unknown_address_out,
  output logic       overrun_out,
  output logic       underrun_out
);

  typedef enum logic [1:0] {
    IDLE,
    ADDRESS,
    PAYLOAD,
    DISCARD
  } state_t;

  localparam logic [7:0] PAYLOAD_LIMIT = 8'(MAX_PAYLOAD);

  state_t state;
  logic   select_q;  // select sampled last cycle, for rising-edge detect
  logic   armed;     // select has been seen low since reset
  logic   select_rise;
  logic   closing;
  logic   address_in_range;

  // A select still high when reset releases is not treated as a new window:
  // a low level must be seen first.
  assign select_rise      = spi_select_in & ~select_q & armed;
  assign closing          = (state != IDLE) & ~spi_select_in;
  assign address_in_range = (rx_byte_in >= ADDRESS_MIN) && (rx_byte_in <= ADDRESS_MAX);

  // Transaction FSM, payload forwarding and the single-entry TX buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      select_q            <= 1'b0;
      armed               <= 1'b0;
      address_out         <= 8'h00;
      address_valid_out   <= 1'b0;
      payload_out         <= 8'h00;
      payload_valid_out   <= 1'b0;
      byte_count_out      <= 8'h00;
      tx_byte_out         <= 8'h00;
      tx_byte_valid_out   <= 1'b0;
      unknown_address_out <= 1'b0;
      overrun_out         <= 1'b0;
      underrun_out        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every branch below sees the
      // values from the start of the cycle (e.g. the old address_valid_out).
      select_q <= spi_select_in;
      armed    <= armed | ~spi_select_in;

      // Pulse outputs default low and are raised for one cycle below.
      payload_valid_out   <= 1'b0;
      unknown_address_out <= 1'b0;
      overrun_out         <= 1'b0;
      underrun_out        <= 1'b0;

      if (closing) begin
        // Window ended: drop everything except the last address.
        // Any rx strobe arriving in this cycle is ignored.
        state             <= IDLE;
        address_valid_out <= 1'b0;
        byte_count_out    <= 8'h00;
        tx_byte_valid_out <= 1'b0;
        tx_byte_out       <= 8'h00;
      end else begin
        case (state)
          IDLE: begin
            if (select_rise) state <= ADDRESS;
          end
          ADDRESS: begin
            if (rx_byte_valid_in) begin
              address_out <= rx_byte_in;
              if (address_in_range) begin
                state             <= PAYLOAD;
                address_valid_out <= 1'b1;
              end else begin
                state               <= DISCARD;
                unknown_address_out <= 1'b1;
              end
            end
          end
          PAYLOAD: begin
            if (rx_byte_valid_in) begin
              if (byte_count_out < PAYLOAD_LIMIT) begin
                payload_out       <= rx_byte_in;
                payload_valid_out <= 1'b1;
                byte_count_out    <= byte_count_out + 8'd1;
              end else begin
                overrun_out <= 1'b1;
                state       <= DISCARD;
              end
            end
          end
          default: ;  // DISCARD: ignore rx bytes until select falls
        endcase

        // The TX buffer only operates while a valid address is held.
        if (address_valid_out) begin
          if (sub_data_valid_in) begin
            // Covers plain load, overwrite, and load-while-consumed.
            tx_byte_out       <= sub_data_in;
            tx_byte_valid_out <= 1'b1;
          end else if (tx_request_in) begin
            if (tx_byte_valid_out) begin
              tx_byte_valid_out <= 1'b0;
            end else begin
              tx_byte_out  <= 8'h00;
              underrun_out <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_transaction_controller.sv
// Bench for spi_transaction_controller. Two instances share the stimulus:
// one with the default payload limit and one with a payload limit of 2.
// A behavioural model tracks each window as simple flags and counters.
module tb_spi_transaction_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel, rxv, sdv, req;
  logic [7:0] rx, sd;

  logic [7:0] addr_o [2];
  logic [7:0] pay_o  [2];
  logic [7:0] cnt_o  [2];
  logic [7:0] txb_o  [2];
  logic       av_o   [2];
  logic       pv_o   [2];
  logic       txv_o  [2];
  logic       unk_o  [2];
  logic       ovr_o  [2];
  logic       und_o  [2];

  spi_transaction_controller dut_a (
    .clock(clk), .reset_n(reset_n), .spi_select_in(sel),
    .rx_byte_in(rx), .rx_byte_valid_in(rxv),
    .address_out(addr_o[0]), .address_valid_out(av_o[0]),
    .payload_out(pay_o[0]), .payload_valid_out(pv_o[0]),
    .byte_count_out(cnt_o[0]),
    .sub_data_in(sd), .sub_data_valid_in(sdv),
    .tx_byte_out(txb_o[0]), .tx_byte_valid_out(txv_o[0]),
    .tx_request_in(req),
    .unknown_address_out(unk_o[0]), .overrun_out(ovr_o[0]), .underrun_out(und_o[0])
  );

  spi_transaction_controller #(.MAX_PAYLOAD(2)) dut_b (
    .clock(clk), .reset_n(reset_n), .spi_select_in(sel),
    .rx_byte_in(rx), .rx_byte_valid_in(rxv),
    .address_out(addr_o[1]), .address_valid_out(av_o[1]),
    .payload_out(pay_o[1]), .payload_valid_out(pv_o[1]),
    .byte_count_out(cnt_o[1]),
    .sub_data_in(sd), .sub_data_valid_in(sdv),
    .tx_byte_out(txb_o[1]), .tx_byte_valid_out(txv_o[1]),
    .tx_request_in(req),
    .unknown_address_out(unk_o[1]), .overrun_out(ovr_o[1]), .underrun_out(und_o[1])
  );

  int tests = 0;
  int fails = 0;

  // Reference model state, one slot per instance.
  int         max_pl [2] = '{255, 2};
  bit         m_armed [2], m_prev [2];
  bit         m_in_window [2], m_have_addr [2], m_ignoring [2];
  logic [7:0] m_addr [2], m_pay [2], m_txb [2];
  int         m_cnt [2];
  bit         m_av [2], m_pv [2], m_txv [2], m_unk [2], m_ovr [2], m_und [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_armed[i] = 0; m_prev[i] = 0;
      m_in_window[i] = 0; m_have_addr[i] = 0; m_ignoring[i] = 0;
      m_addr[i] = 8'h00; m_pay[i] = 8'h00; m_txb[i] = 8'h00; m_cnt[i] = 0;
      m_av[i] = 0; m_pv[i] = 0; m_txv[i] = 0; m_unk[i] = 0; m_ovr[i] = 0; m_und[i] = 0;
    end
  endtask

  // One clock of the specified behaviour, applied to the current inputs.
  task automatic model_clock();
    for (int i = 0; i < 2; i++) begin
      bit had_addr_valid;
      had_addr_valid = m_av[i];
      m_pv[i] = 0; m_unk[i] = 0; m_ovr[i] = 0; m_und[i] = 0;
      if (!m_in_window[i]) begin
        if (sel && !m_prev[i] && m_armed[i]) begin
          m_in_window[i] = 1; m_have_addr[i] = 0; m_ignoring[i] = 0;
        end
      end else if (!sel) begin
        m_in_window[i] = 0;
        m_av[i] = 0; m_cnt[i] = 0; m_txv[i] = 0; m_txb[i] = 8'h00;
      end else begin
        if (rxv && !m_ignoring[i]) begin
          if (!m_have_addr[i]) begin
            m_have_addr[i] = 1;
            m_addr[i] = rx;
            if (rx >= 8'hDB && rx <= 8'hDC) m_av[i] = 1;
            else begin m_unk[i] = 1; m_ignoring[i] = 1; end
          end else if (m_cnt[i] < max_pl[i]) begin
            m_pay[i] = rx; m_pv[i] = 1; m_cnt[i]++;
          end else begin
            m_ovr[i] = 1; m_ignoring[i] = 1;
          end
        end
        if (had_addr_valid) begin
          if (sdv) begin
            m_txb[i] = sd; m_txv[i] = 1;
          end else if (req) begin
            if (m_txv[i]) m_txv[i] = 0;
            else begin m_txb[i] = 8'h00; m_und[i] = 1; end
          end
        end
      end
      m_prev[i] = sel;
      m_armed[i] = m_armed[i] | !sel;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s.%0d.address", tag, i), addr_o[i], m_addr[i]);
      check($sformatf("%s.%0d.address_valid", tag, i), {7'd0, av_o[i]}, {7'd0, m_av[i]});
      check($sformatf("%s.%0d.payload", tag, i), pay_o[i], m_pay[i]);
      check($sformatf("%s.%0d.payload_valid", tag, i), {7'd0, pv_o[i]}, {7'd0, m_pv[i]});
      check($sformatf("%s.%0d.byte_count", tag, i), cnt_o[i], 8'(m_cnt[i]));
      check($sformatf("%s.%0d.tx_byte", tag, i), txb_o[i], m_txb[i]);
      check($sformatf("%s.%0d.tx_valid", tag, i), {7'd0, txv_o[i]}, {7'd0, m_txv[i]});
      check($sformatf("%s.%0d.unknown", tag, i), {7'd0, unk_o[i]}, {7'd0, m_unk[i]});
      check($sformatf("%s.%0d.overrun", tag, i), {7'd0, ovr_o[i]}, {7'd0, m_ovr[i]});
      check($sformatf("%s.%0d.underrun", tag, i), {7'd0, und_o[i]}, {7'd0, m_und[i]});
    end
  endtask

  // Drive one cycle of inputs after a falling edge, clock it, check at the next falling edge.
  task automatic step(input string tag, input logic s, input logic v, input logic [7:0] b,
                      input logic l, input logic [7:0] d, input logic r);
    sel = s; rxv = v; rx = b; sdv = l; sd = d; req = r;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic s);
    step(tag, s, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rx_byte(input string tag, input logic [7:0] b);
    step(tag, 1'b1, 1'b1, b, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    sel = 0; rxv = 0; rx = 8'h00; sdv = 0; sd = 8'h00; req = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;
    idle("arm", 1'b0);
    idle("arm", 1'b0);

    // Basic write: address DB then three payload bytes.
    idle("t1_cs", 1'b1);
    idle("t1_wait", 1'b1);
    rx_byte("t1_addr", 8'hDB);
    check("t1_addr_value", addr_o[0], 8'hDB);
    check("t1_addr_valid", {7'd0, av_o[0]}, 8'h01);
    rx_byte("t1_p1", 8'h11);
    check("t1_p1_data", pay_o[0], 8'h11);
    check("t1_p1_count", cnt_o[0], 8'd1);
    rx_byte("t1_p2", 8'h22);
    rx_byte("t1_p3", 8'h33);
    check("t1_p3_data", pay_o[0], 8'h33);
    check("t1_p3_count", cnt_o[0], 8'd3);
    idle("t1_cs_low", 1'b0);
    check("t1_close_valid", {7'd0, av_o[0]}, 8'h00);
    check("t1_close_count", cnt_o[0], 8'd0);

    // Unknown address.
    idle("t2_cs", 1'b1);
    idle("t2_wait", 1'b1);
    rx_byte("t2_addr", 8'h5A);
    check("t2_unknown", {7'd0, unk_o[0]}, 8'h01);
    rx_byte("t2_next", 8'h01);
    check("t2_unknown_once", {7'd0, unk_o[0]}, 8'h00);
    check("t2_no_payload", {7'd0, pv_o[0]}, 8'h00);
    check("t2_addr_invalid", {7'd0, av_o[0]}, 8'h00);
    idle("t2_cs_low", 1'b0);

    // Overrun on the limit-2 instance.
    idle("t3_cs", 1'b1);
    idle("t3_wait", 1'b1);
    rx_byte("t3_addr", 8'hDC);
    rx_byte("t3_a1", 8'hA1);
    rx_byte("t3_a2", 8'hA2);
    check("t3_a2_count", cnt_o[1], 8'd2);
    rx_byte("t3_a3", 8'hA3);
    check("t3_overrun", {7'd0, ovr_o[1]}, 8'h01);
    check("t3_not_forwarded", {7'd0, pv_o[1]}, 8'h00);
    check("t3_count_held", cnt_o[1], 8'd2);
    rx_byte("t3_a4", 8'hA4);
    check("t3_valid_kept", {7'd0, av_o[1]}, 8'h01);
    idle("t3_cs_low", 1'b0);
    check("t3_valid_cleared", {7'd0, av_o[1]}, 8'h00);

    // TX buffer behaviour.
    idle("t4_cs", 1'b1);
    idle("t4_wait", 1'b1);
    rx_byte("t4_addr", 8'hDB);
    step("t4_load", 1'b1, 1'b0, 8'h00, 1'b1, 8'h7E, 1'b0);
    check("t4_tx_byte", txb_o[0], 8'h7E);
    check("t4_tx_valid", {7'd0, txv_o[0]}, 8'h01);
    idle("t4_hold", 1'b1);
    step("t4_req", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("t4_consumed", {7'd0, txv_o[0]}, 8'h00);
    step("t4_req_empty", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("t4_underrun", {7'd0, und_o[0]}, 8'h01);
    check("t4_underrun_byte", txb_o[0], 8'h00);
    step("t4_load10", 1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0);
    step("t4_load20", 1'b1, 1'b0, 8'h00, 1'b1, 8'h20, 1'b0);
    check("t4_newest_wins", txb_o[0], 8'h20);
    step("t5_load33", 1'b1, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0);
    step("t5_load44_req", 1'b1, 1'b0, 8'h00, 1'b1, 8'h44, 1'b1);
    check("t5_tx_byte", txb_o[0], 8'h44);
    check("t5_tx_valid", {7'd0, txv_o[0]}, 8'h01);
    check("t5_no_underrun", {7'd0, und_o[0]}, 8'h00);
    idle("t5_cs_low", 1'b0);
    check("t5_tx_cleared", {7'd0, txv_o[0]}, 8'h00);

    // Asynchronous reset mid-transaction with select still high.
    idle("t6_cs", 1'b1);
    idle("t6_wait", 1'b1);
    rx_byte("t6_addr", 8'hDC);
    rxv = 0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    rx_byte("t6_after_rst1", 8'hDB);
    rx_byte("t6_after_rst2", 8'hA5);
    rx_byte("t6_after_rst3", 8'hA6);
    check("t6_no_payload", {7'd0, pv_o[0]}, 8'h00);
    check("t6_no_addr_valid", {7'd0, av_o[0]}, 8'h00);
    idle("t6_cs_low", 1'b0);
    idle("t6_cs_rise", 1'b1);
    idle("t6_wait2", 1'b1);
    rx_byte("t6_addr2", 8'hDB);
    rx_byte("t6_pay", 8'h55);
    check("t6_payload_resumes", pay_o[0], 8'h55);

    // Randomised windows.
    for (int t = 0; t < 40; t++) begin
      int gap, len;
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++)
        step("rnd_gap", 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 8'h00, 1'b0);
      len = $urandom_range(3, 14);
      for (int c = 0; c < len; c++) begin
        logic [7:0] b, d;
        logic v, l, r;
        v = 1'($urandom_range(0, 1));
        if (!m_have_addr[0]) begin
          case ($urandom_range(0, 4))
            0: b = 8'hDA;
            1: b = 8'hDB;
            2: b = 8'hDC;
            3: b = 8'hDD;
            default: b = 8'($urandom);
          endcase
        end else begin
          b = 8'($urandom);
        end
        d = 8'($urandom);
        l = ($urandom_range(0, 2) == 0);
        r = ($urandom_range(0, 2) == 0) && m_av[0];
        if (l && (!m_txv[0] || !m_txv[1])) r = 1'b0;
        step("rnd", 1'b1, v, b, l, d, r);
      end
    end
    idle("rnd_end", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_transaction_controller.md
Name: spi_transaction_controller

Overview:
- Sequences one SPI transaction per chip-select window, between the SPI byte engine and the subperipheral selector.
- The first received byte is latched as the subperipheral address and held valid for the rest of the window.
- Each later byte is forwarded as a write-data strobe, bounded by a payload limit.
- Also buffers the selected subperipheral's response byte for the byte engine's next shift-out.

Parameters:
ADDRESS_MIN, 8'hDB, lowest accepted subperipheral address
ADDRESS_MAX, 8'hDC, highest accepted subperipheral address
MAX_PAYLOAD, 255, maximum payload bytes forwarded per transaction (1..255)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
spi_select_in  in  1  transaction active (synchronised CS, active high)
rx_byte_in  in  8  received byte
rx_byte_valid_in  in  1  one-cycle strobe, rx_byte_in valid
address_out  out  8  latched subperipheral address
address_valid_out  out  1  address_out valid; feeds the selector enable
payload_out  out  8  write-data byte to subperipherals
payload_valid_out  out  1  one-cycle strobe for payload_out
byte_count_out  out  8  payload bytes forwarded this transaction
sub_data_in  in  8  response byte from the selector
sub_data_valid_in  in  1  sub_data_in valid
tx_byte_out  out  8  byte for the next shift-out
tx_byte_valid_out  out  1  tx_byte_out holds an unconsumed byte
tx_request_in  in  1  one-cycle strobe: byte engine takes tx_byte_out
unknown_address_out  out  1  one-cycle pulse: address outside range
overrun_out  out  1  one-cycle pulse: byte beyond MAX_PAYLOAD
underrun_out  out  1  one-cycle pulse: tx_request_in with nothing buffered

Behaviour:
- Reset: all outputs 0. State = IDLE. Internal select-edge register = 0.
- States: IDLE, ADDRESS, PAYLOAD, DISCARD.
- IDLE: on spi_select_in rising edge (registered edge detect), go to ADDRESS next cycle.
- ADDRESS, on rx_byte_valid_in:
  - Latch rx_byte_in into address_out.
  - If ADDRESS_MIN <= byte <= ADDRESS_MAX: go to PAYLOAD and set address_valid_out the next cycle.
  - Otherwise: go to DISCARD, pulse unknown_address_out, and keep address_valid_out at 0.
- PAYLOAD, on rx_byte_valid_in:
  - If byte_count_out < MAX_PAYLOAD: register the byte to payload_out, pulse payload_valid_out (latency 1 clock) and increment byte_count_out.
  - Otherwise: pulse overrun_out, forward nothing, and go to DISCARD. byte_count_out holds at MAX_PAYLOAD and never wraps.
- DISCARD: ignore rx bytes. address_valid_out stays at its current value, so after an overrun it remains 1 until CS falls.
- spi_select_in low in any non-IDLE state:
  - Go to IDLE the next cycle.
  - Clear address_valid_out and byte_count_out. address_out keeps its last value.
  - Clear tx_byte_valid_out.
  - An rx_byte_valid_in in the same cycle as select low is dropped.
- CS re-asserted while in IDLE starts a fresh transaction. No state carries over except address_out.
- TX buffer (single entry), active only while address_valid_out = 1:
  - sub_data_valid_in loads tx_byte_out and sets tx_byte_valid_out.
  - tx_request_in with valid set clears valid next cycle.
  - Load and request in the same cycle: the old byte is consumed, the new byte is loaded, and valid stays 1.
  - Load while valid with no request: overwrite, newest byte wins.
  - tx_request_in with valid = 0: tx_byte_out is forced to 8'h00 and underrun_out pulses.
  - While address_valid_out = 0: tx_byte_out = 8'h00 and loads are ignored.
- Asynchronous reset mid-transaction: immediate return to reset values. The block waits for a new CS rising edge; a CS still held high after reset release does not start a transaction.

Test Plan:
- CS high, bytes DB,11,22,33, CS low -> address_out=DB; address_valid_out=1 one cycle after the DB strobe; payload strobes 11,22,33 at +1 clock each; byte_count 1,2,3; valid and count cleared one cycle after CS low.
- CS high, byte 0x5A then 0x01 -> unknown_address_out single pulse, address_valid_out stays 0, no payload strobe.
- MAX_PAYLOAD=2, bytes DC,A1,A2,A3 -> A1 and A2 forwarded, A3 triggers overrun_out and is not forwarded, byte_count holds 2, address_valid_out=1 until CS low.
- Address DB, sub_data_valid_in with 0x7E, then tx_request_in -> tx_byte_out=7E with valid 1 until the request, then valid 0. A second request with no new data -> underrun_out, tx_byte_out=00. Then load 0x10 followed by load 0x20 with no request -> tx_byte_out=20.
- Load 0x44 in the same cycle as tx_request_in while holding 0x33 -> 33 consumed, tx_byte_out=44, valid stays 1.
- Assert reset_n low after the DC byte with CS still high, release -> all outputs 0, no payload forwarded until a CS fall and re-rise.
